// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the register file and its scoreboard.
// Used by the register file, the decoder and the issue logic.
package reg_file_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 4;

    // Where a read port takes its next output value from.
    typedef enum logic [1:0] {
        SRC_REG    = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_ZERO   = 2'd2
    } rd_src_e;

    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // A write landing on the read address wins over everything else.
    // Writes to a hard-wired zero register never reach this point,
    // because the caller qualifies wr_hit with that rule first.
    function automatic rd_src_e read_src(input logic wr_hit, input logic zero_hit);
        if (wr_hit) begin
            return SRC_BYPASS;
        end
        if (zero_hit) begin
            return SRC_ZERO;
        end
        return SRC_REG;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Read, write-back and mark bus between the execute stage and the register file.
// The master is the requester; the slave is reg_file_sb.
interface reg_file_sb_if #(
    parameter int WIDTH = reg_file_pkg::DEFAULT_WIDTH,
    parameter int DEPTH = reg_file_pkg::DEFAULT_DEPTH
);
    localparam int AW = reg_file_pkg::addr_width(DEPTH);

    logic             rd_req;
    logic [AW-1:0]    rd_addr;
    logic [AW-1:0]    rs_addr;
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] rs_q;
    logic             rd_vld;
    logic             stall;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    logic             mark_en;
    logic [AW-1:0]    mark_addr;
    logic [DEPTH-1:0] busy;

    modport master (
        output rd_req, rd_addr, rs_addr,
        output wr_en, wr_addr, wr_data,
        output mark_en, mark_addr,
        input  rd_q, rs_q, rd_vld, stall, busy
    );

    modport slave (
        input  rd_req, rd_addr, rs_addr,
        input  wr_en, wr_addr, wr_data,
        input  mark_en, mark_addr,
        output rd_q, rs_q, rd_vld, stall, busy
    );

endinterface

// File: rtl/reg_file_cell.sv
// One register of the file plus its scoreboard busy flag.
// A mark in the same cycle as a write-back wins: a new producer has issued.
module reg_file_cell #(
    parameter int WIDTH = reg_file_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             mark_en,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    // NOTE: the data register is reset too (not left as uninitialised
    // storage) because software relies on all registers reading 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            busy <= 1'b0;
        end else begin
            if (wr_en) begin
                q <= wr_data;
            end
            if (mark_en) begin
                busy <= 1'b1;
            end else if (wr_en) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard, two registered read ports,
// one write-back port and write-to-read bypass for same-cycle write-backs.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_sb_if.slave bus
);

    localparam int AW = addr_width(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy_vec;

    logic wr_ok;
    logic mark_ok;

    // With ZERO_R0 set, register 0 never sees a write or a mark, so its data
    // and busy flops stay at their reset value of 0 forever.
    assign wr_ok   = bus.wr_en   && !(ZERO_R0 && (bus.wr_addr   == '0));
    assign mark_ok = bus.mark_en && !(ZERO_R0 && (bus.mark_addr == '0));

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        reg_file_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_ok   && (bus.wr_addr   == AW'(i))),
            .wr_data (bus.wr_data),
            .mark_en (mark_ok && (bus.mark_addr == AW'(i))),
            .q       (regs[i]),
            .busy    (busy_vec[i])
        );
    end

    assign bus.busy = busy_vec;

    logic hit_rd;
    logic hit_rs;
    logic hz_rd;
    logic hz_rs;
    logic stall;
    logic accept;

    assign hit_rd = wr_ok && (bus.wr_addr == bus.rd_addr);
    assign hit_rs = wr_ok && (bus.wr_addr == bus.rs_addr);

    // mark_en feeds only the busy flops, so a mark affects stall one cycle later.
    assign hz_rd  = busy_vec[bus.rd_addr] && !hit_rd;
    assign hz_rs  = busy_vec[bus.rs_addr] && !hit_rs;
    assign stall  = bus.rd_req && (hz_rd || hz_rs);
    assign accept = bus.rd_req && !stall;

    assign bus.stall = stall;

    rd_src_e          src_rd;
    rd_src_e          src_rs;
    logic [WIDTH-1:0] rd_next;
    logic [WIDTH-1:0] rs_next;

    assign src_rd = read_src(hit_rd, ZERO_R0 && (bus.rd_addr == '0));
    assign src_rs = read_src(hit_rs, ZERO_R0 && (bus.rs_addr == '0));

    always_comb begin
        // NOTE: each output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        rd_next = regs[bus.rd_addr];
        rs_next = regs[bus.rs_addr];
        unique case (src_rd)
            SRC_BYPASS: rd_next = bus.wr_data;
            SRC_ZERO:   rd_next = '0;
            default:    ;
        endcase
        unique case (src_rs)
            SRC_BYPASS: rs_next = bus.wr_data;
            SRC_ZERO:   rs_next = '0;
            default:    ;
        endcase
    end

    // Both ports load together; a rejected request clears the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_q   <= '0;
            bus.rs_q   <= '0;
            bus.rd_vld <= 1'b0;
        end else if (accept) begin
            bus.rd_q   <= rd_next;
            bus.rs_q   <= rs_next;
            bus.rd_vld <= 1'b1;
        end else begin
            bus.rd_q   <= '0;
            bus.rs_q   <= '0;
            bus.rd_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default configuration plus ZERO_R0=1, DEPTH=8, WIDTH=32.
// Expected read results go into a scoreboard queue when a read is driven.
module tb_reg_file_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_sb_if #(.WIDTH(16), .DEPTH(4)) bus_a ();
    reg_file_sb_if #(.WIDTH(32), .DEPTH(8)) bus_b ();

    reg_file_sb #(.WIDTH(16), .DEPTH(4), .ZERO_R0(1'b0)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    reg_file_sb #(.WIDTH(32), .DEPTH(8), .ZERO_R0(1'b1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        logic [31:0] rd;
        logic [31:0] rs;
    } exp_t;

    exp_t sb_q[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        bus_a.rd_req = 1'b0; bus_a.rd_addr = '0; bus_a.rs_addr = '0;
        bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
        bus_a.mark_en = 1'b0; bus_a.mark_addr = '0;
        bus_b.rd_req = 1'b0; bus_b.rd_addr = '0; bus_b.rs_addr = '0;
        bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
        bus_b.mark_en = 1'b0; bus_b.mark_addr = '0;
    endtask

    // One clock cycle on DUT a (sel=0) or b (sel=1). Starts just after a rising
    // edge: drive, check the combinational stall, then check the registered
    // outputs just after the next edge against the scoreboard.
    task automatic step(input bit sel, input logic req, input logic [2:0] ra,
                        input logic [2:0] rsa, input logic we, input logic [2:0] wa,
                        input logic [31:0] wd, input logic me, input logic [2:0] ma,
                        input logic exp_stall, input logic [31:0] exp_rd,
                        input logic [31:0] exp_rs, input string tag);
        exp_t e;
        idle_all();
        if (!sel) begin
            bus_a.rd_req = req; bus_a.rd_addr = ra[1:0]; bus_a.rs_addr = rsa[1:0];
            bus_a.wr_en = we; bus_a.wr_addr = wa[1:0]; bus_a.wr_data = wd[15:0];
            bus_a.mark_en = me; bus_a.mark_addr = ma[1:0];
        end else begin
            bus_b.rd_req = req; bus_b.rd_addr = ra; bus_b.rs_addr = rsa;
            bus_b.wr_en = we; bus_b.wr_addr = wa; bus_b.wr_data = wd;
            bus_b.mark_en = me; bus_b.mark_addr = ma;
        end
        #1;
        check({tag, ".stall"}, sel ? bus_b.stall : bus_a.stall, exp_stall);
        if (req && !exp_stall && !rst) begin
            e.rd = exp_rd;
            e.rs = exp_rs;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, ".rd_vld"}, sel ? bus_b.rd_vld : bus_a.rd_vld, 1'b1);
            check({tag, ".rd_q"}, sel ? bus_b.rd_q : 32'(bus_a.rd_q), e.rd);
            check({tag, ".rs_q"}, sel ? bus_b.rs_q : 32'(bus_a.rs_q), e.rs);
        end else begin
            check({tag, ".rd_vld"}, sel ? bus_b.rd_vld : bus_a.rd_vld, 1'b0);
            check({tag, ".rd_q"}, sel ? bus_b.rd_q : 32'(bus_a.rd_q), 32'h0);
            check({tag, ".rs_q"}, sel ? bus_b.rs_q : 32'(bus_a.rs_q), 32'h0);
        end
    endtask

    task automatic check_busy(input bit sel, input logic [7:0] exp, input string tag);
        check({tag, ".busy"}, sel ? bus_b.busy : 8'(bus_a.busy), exp);
    endtask

    initial begin
        idle_all();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset.rd_vld_a", bus_a.rd_vld, 1'b0);
        check("reset.rd_q_a", bus_a.rd_q, 16'h0);
        check("reset.busy_a", bus_a.busy, 4'h0);
        check("reset.busy_b", bus_b.busy, 8'h0);
        check("reset.stall_a", bus_a.stall, 1'b0);
        rst = 1'b0;

        // Default configuration: WIDTH=16, DEPTH=4, ZERO_R0=0
        step(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, "reset_read");
        step(0, 1, 2, 1, 1, 2, 32'hA5A5, 0, 0, 0, 32'hA5A5, 32'h0, "bypass_read");
        step(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 32'hA5A5, 32'h0, "stored_read");
        step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, "mark3");
        check_busy(0, 8'h08, "mark3");
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, "stall3");
        end
        step(0, 1, 0, 3, 1, 3, 32'h1234, 0, 0, 0, 32'h0, 32'h1234, "wb3");
        check_busy(0, 8'h00, "wb3");

        step(0, 0, 0, 0, 1, 1, 32'hBEEF, 1, 1, 0, 0, 0, "mark_wr1");
        check_busy(0, 8'h02, "mark_wr1");
        step(0, 1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, "stall1");
        step(0, 0, 0, 0, 1, 1, 32'hBEEF, 0, 0, 0, 0, 0, "clear1");
        check_busy(0, 8'h00, "clear1");
        step(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 32'hBEEF, 32'h1234, "read1_3");

        // A mark must not stall the read issued in the same cycle.
        step(0, 1, 0, 2, 0, 0, 0, 1, 0, 0, 32'h0, 32'hA5A5, "mark0_same");
        check_busy(0, 8'h01, "mark0_same");
        step(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, "stall0");
        step(0, 0, 0, 0, 1, 0, 32'h7777, 0, 0, 0, 0, 0, "clear0");
        check_busy(0, 8'h00, "clear0");

        // Reset in the middle of a stall
        step(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, "mark2");
        step(0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, "stall2");
        rst = 1'b1;
        step(0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, "rst_in_stall");
        check_busy(0, 8'h00, "rst_in_stall");
        rst = 1'b0;
        step(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, "after_rst");

        // ZERO_R0=1, DEPTH=8, WIDTH=32
        step(1, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, "z_wr_mark0");
        check_busy(1, 8'h00, "z_wr_mark0");
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, "z_read0");
        step(1, 0, 0, 0, 1, 7, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, "z_wr7");
        step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h0, "z_read7");
        step(1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, "z_mark5");
        step(1, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, "z_mark6");
        check_busy(1, 8'h60, "z_mark56");
        // rd port is cleared by the write-back but rs still blocks: no partial accept.
        step(1, 1, 5, 6, 1, 5, 32'h5555_0005, 0, 0, 1, 0, 0, "z_partial");
        check_busy(1, 8'h40, "z_partial");
        step(1, 1, 5, 6, 1, 6, 32'h6666_0006, 0, 0, 0, 32'h5555_0005, 32'h6666_0006, "z_wb6");
        check_busy(1, 8'h00, "z_wb6");
        step(1, 1, 7, 6, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h6666_0006, "z_b2b");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
